fft_sdf_r2_stage: RTL and testbench

Streaming radix-2 DIF single-path delay-feedback (SDF) FFT stage. It accepts one complex sample per valid cycle and produces one complex result per valid cycle. It generalises the fixed 32-input parallel stage to any power-of-two butterfly span, parametrised widths and an internal twiddle multiply. Instances are cascaded with P_DELAY = N/2, N/4, ... 1 to form an N-point streaming FFT.

---
 rtl/fft_pkg.sv | 45 ++++
 rtl/fft_cmul_rs.sv | 34 +++
 rtl/fft_sdf_r2_stage.sv | 150 +++++++++++++++
 tb/tb_fft_sdf_r2_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared helpers for the streaming FFT stages: complex packing (real in MSBs),
// round-half-up with saturation, and a constant clog2.
`define FFT_CRE(v, w) v[2*(w)-1:(w)]
`define FFT_CIM(v, w) v[(w)-1:0]
`define FFT_CPACK(re, im) {re, im}

package fft_pkg;

  localparam int unsigned FFT_ACC_BITS = 64;

  function automatic int unsigned fft_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 32'd1;
    end
    return r;
  endfunction

  // Round half-up by frac bits, then clip to a signed width-bit range.
  function automatic logic signed [FFT_ACC_BITS-1:0] fft_round_sat(
    input  logic signed [FFT_ACC_BITS-1:0] x,
    input  int unsigned                    width,
    input  int unsigned                    frac,
    output logic                           sat
  );
    logic signed [FFT_ACC_BITS-1:0] r;
    logic signed [FFT_ACC_BITS-1:0] hi;
    logic signed [FFT_ACC_BITS-1:0] lo;
    if (frac == 32'd0) r = x;
    else               r = (x + (64'sd1 <<< (frac - 32'd1))) >>> frac;
    hi  = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 32'd1));
    sat = 1'b0;
    if (r > hi) begin
      r   = hi;
      sat = 1'b1;
    end else if (r < lo) begin
      r   = lo;
      sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_cmul_rs.sv
// Complex multiply a*w with exact products, round-half-up and saturation to the
// width of a. Purely combinational so later stages can drop it into their datapath.
module fft_cmul_rs
  import fft_pkg::*;
#(
  parameter int unsigned P_A_BITS  = 9,
  parameter int unsigned P_TW_BITS = 8,
  parameter int unsigned P_TW_FRAC = 6
) (
  input  logic [2*P_A_BITS-1:0]  i_a,
  input  logic [2*P_TW_BITS-1:0] i_w,
  output logic [2*P_A_BITS-1:0]  o_y_c,
  output logic                   o_sat_c
);

  logic signed [P_A_BITS-1:0]     ar, ai;
  logic signed [P_TW_BITS-1:0]    wr, wi;
  logic signed [FFT_ACC_BITS-1:0] pr, pi, yr, yi;
  logic                           sr, si;

  always_comb begin
    ar = `FFT_CRE(i_a, P_A_BITS);
    ai = `FFT_CIM(i_a, P_A_BITS);
    wr = `FFT_CRE(i_w, P_TW_BITS);
    wi = `FFT_CIM(i_w, P_TW_BITS);
    pr = FFT_ACC_BITS'(ar) * FFT_ACC_BITS'(wr) - FFT_ACC_BITS'(ai) * FFT_ACC_BITS'(wi);
    pi = FFT_ACC_BITS'(ar) * FFT_ACC_BITS'(wi) + FFT_ACC_BITS'(ai) * FFT_ACC_BITS'(wr);
    yr = fft_round_sat(pr, P_A_BITS, P_TW_FRAC, sr);
    yi = fft_round_sat(pi, P_A_BITS, P_TW_FRAC, si);
    o_y_c   = `FFT_CPACK(P_A_BITS'(yr), P_A_BITS'(yi));
    o_sat_c = sr | si;
  end

endmodule

// File: rtl/fft_sdf_r2_stage.sv
// Radix-2 DIF single-path delay-feedback FFT stage: span D delay line, sums out
// in the second half-frame, twiddled differences flushed by the next frame.
module fft_sdf_r2_stage
  import fft_pkg::*;
#(
  parameter int unsigned P_DATA_BITS = 8,
  parameter int unsigned P_TW_BITS   = 8,
  parameter int unsigned P_TW_FRAC   = 6,
  parameter int unsigned P_DELAY     = 16,
  localparam int unsigned AW = (fft_clog2(P_DELAY) > 0) ? fft_clog2(P_DELAY) : 1,
  localparam int unsigned DW = P_DATA_BITS + 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     i_valid,
  input  logic                     i_sof,
  input  logic [2*P_DATA_BITS-1:0] i_data,
  input  logic [2*P_TW_BITS-1:0]   i_tw,
  output logic [AW-1:0]            o_tw_addr,
  output logic                     o_valid,
  output logic                     o_sof,
  output logic                     o_half,
  output logic [2*DW-1:0]          o_data,
  output logic                     o_sat,
  output logic                     o_err
);

  localparam int unsigned CW = fft_clog2(P_DELAY) + 1;

  logic [CW-1:0]   cnt_q, cnt_d, cnt_eff;
  logic            diff_ok_q, diff_ok_d, dok, err_c, phase_b;
  logic            valid_q, valid_d, sof_q, sof_d, half_q, half_d;
  logic            sat_q, sat_d, err_q, err_d;
  logic [2*DW-1:0] data_q, data_d;
  logic [2*DW-1:0] head, push_d, x_ext, sum_c, dif_c, mul_y;
  logic            mul_sat;
  logic signed [P_DATA_BITS-1:0] xr, xi;
  logic signed [DW-1:0]          xre, xie, hr, hi;

  // Delay line: the head is always the entry pushed D accepted samples ago.
  generate
    if (P_DELAY == 1) begin : g_reg
      logic [2*DW-1:0] line_q;
      always_ff @(posedge CLK) begin
        if (i_valid) line_q <= push_d;
      end
      assign head      = line_q;
      assign o_tw_addr = '0;
    end else begin : g_ram
      logic [2*DW-1:0] mem_q [P_DELAY];
      logic [AW-1:0]   ptr_q;
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST)         ptr_q <= '0;
        else if (i_valid) ptr_q <= ptr_q + AW'(1);
      end
      always_ff @(posedge CLK) begin
        if (i_valid) mem_q[ptr_q] <= push_d;
      end
      assign head      = mem_q[ptr_q];
      assign o_tw_addr = cnt_q[AW-1:0];
    end
  endgenerate

  fft_cmul_rs #(
    .P_A_BITS  (DW),
    .P_TW_BITS (P_TW_BITS),
    .P_TW_FRAC (P_TW_FRAC)
  ) u_cmul (
    .i_a     (head),
    .i_w     (i_tw),
    .o_y_c   (mul_y),
    .o_sat_c (mul_sat)
  );

  always_comb begin
    xr    = `FFT_CRE(i_data, P_DATA_BITS);
    xi    = `FFT_CIM(i_data, P_DATA_BITS);
    xre   = DW'(xr);
    xie   = DW'(xi);
    hr    = `FFT_CRE(head, DW);
    hi    = `FFT_CIM(head, DW);
    x_ext = `FFT_CPACK(xre, xie);
    sum_c = `FFT_CPACK(hr + xre, hi + xie);
    dif_c = `FFT_CPACK(hr - xre, hi - xie);
  end

  always_comb begin
    cnt_eff   = i_sof ? '0 : cnt_q;
    err_c     = i_sof && (cnt_q != '0);
    dok       = diff_ok_q && !err_c;
    phase_b   = cnt_eff[CW-1];
    cnt_d     = cnt_q;
    diff_ok_d = diff_ok_q;
    push_d    = x_ext;
    valid_d   = 1'b0;
    sof_d     = 1'b0;
    err_d     = 1'b0;
    half_d    = half_q;
    sat_d     = sat_q;
    data_d    = data_q;
    if (i_valid) begin
      cnt_d     = cnt_eff + CW'(1);
      diff_ok_d = dok || (cnt_eff == '1);
      err_d     = err_c;
      if (phase_b) begin
        push_d  = dif_c;
        valid_d = 1'b1;
        half_d  = 1'b0;
        sat_d   = 1'b0;
        data_d  = sum_c;
        sof_d   = (cnt_eff == CW'(P_DELAY));
      end else if (dok) begin
        valid_d = 1'b1;
        half_d  = 1'b1;
        sat_d   = mul_sat;
        data_d  = mul_y;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q     <= '0;
      diff_ok_q <= 1'b0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      half_q    <= 1'b0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      diff_ok_q <= diff_ok_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      half_q    <= half_d;
      sat_q     <= sat_d;
      err_q     <= err_d;
      data_q    <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_sof   = sof_q;
  assign o_half  = half_q;
  assign o_sat   = sat_q;
  assign o_err   = err_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_fft_sdf_r2_stage.sv
// Bench for fft_sdf_r2_stage (D=4): directed frames plus random traffic checked
// against a frame-array model of the radix-2 DIF butterfly.
module tb_fft_sdf_r2_stage;

  localparam int D = 4;

  logic        CLK, RST, i_valid, i_sof;
  logic [15:0] i_data, i_tw;
  logic [1:0]  o_tw_addr;
  logic        o_valid, o_sof, o_half, o_sat, o_err;
  logic [17:0] o_data;

  logic [15:0] tw_rom [D];
  assign i_tw = tw_rom[o_tw_addr];

  fft_sdf_r2_stage #(
    .P_DATA_BITS (8),
    .P_TW_BITS   (8),
    .P_TW_FRAC   (6),
    .P_DELAY     (D)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .i_valid   (i_valid),
    .i_sof     (i_sof),
    .i_data    (i_data),
    .i_tw      (i_tw),
    .o_tw_addr (o_tw_addr),
    .o_valid   (o_valid),
    .o_sof     (o_sof),
    .o_half    (o_half),
    .o_data    (o_data),
    .o_sat     (o_sat),
    .o_err     (o_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          pos;
  bit          prev_ok;
  int          cur_re [2*D], cur_im [2*D], prev_re [2*D], prev_im [2*D];
  logic [17:0] last_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] pack(input int re, input int im);
    logic [31:0] r, i;
    r = re;
    i = im;
    return {r[8:0], i[8:0]};
  endfunction

  function automatic int clip(input int v, inout bit s);
    if (v > 255)  begin s = 1'b1; return 255;  end
    if (v < -256) begin s = 1'b1; return -256; end
    return v;
  endfunction

  // (ar + j ai) * W with W in Q1.6, rounded half-up and clipped to 9 bits.
  function automatic void ref_mul(input int ar, input int ai, input logic [15:0] w,
                                  output int yr, output int yi, output bit s);
    logic [7:0] wrb, wib;
    int wr, wi;
    wrb = w[15:8];
    wib = w[7:0];
    wr  = int'($signed(wrb));
    wi  = int'($signed(wib));
    s   = 1'b0;
    yr  = clip((ar * wr - ai * wi + 32) >>> 6, s);
    yi  = clip((ar * wi + ai * wr + 32) >>> 6, s);
  endfunction

  task automatic model_reset();
    pos       = 0;
    prev_ok   = 1'b0;
    last_data = '0;
  endtask

  task automatic send(input int xr, input int xi, input bit sof);
    bit          ev, eh, es, esat, eerr;
    logic [17:0] ed;
    logic [7:0]  br, bi;
    int          yr, yi;
    @(negedge CLK);
    br      = 8'(xr);
    bi      = 8'(xi);
    i_valid = 1'b1;
    i_sof   = sof;
    i_data  = {br, bi};
    #1;
    check("tw_addr", 32'(o_tw_addr), 32'(pos % D));
    eerr = sof && (pos != 0);
    if (sof) begin
      if (pos != 0) prev_ok = 1'b0;
      pos = 0;
    end
    cur_re[pos] = xr;
    cur_im[pos] = xi;
    ev = 0; eh = 0; es = 0; esat = 0; ed = '0;
    if (pos < D) begin
      if (prev_ok) begin
        ref_mul(prev_re[pos] - prev_re[pos+D], prev_im[pos] - prev_im[pos+D],
                tw_rom[pos], yr, yi, esat);
        ev = 1; eh = 1; ed = pack(yr, yi);
      end
    end else begin
      ev = 1;
      es = (pos == D);
      ed = pack(cur_re[pos-D] + xr, cur_im[pos-D] + xi);
    end
    pos++;
    if (pos == 2*D) begin
      prev_re = cur_re;
      prev_im = cur_im;
      prev_ok = 1'b1;
      pos     = 0;
    end
    @(posedge CLK);
    #1;
    check("valid", 32'(o_valid), 32'(ev));
    check("err", 32'(o_err), 32'(eerr));
    if (ev) begin
      check("half", 32'(o_half), 32'(eh));
      check("sof", 32'(o_sof), 32'(es));
      check("data", 32'(o_data), 32'(ed));
      check("sat", 32'(o_sat), 32'(esat));
      last_data = ed;
    end else begin
      check("data_hold", 32'(o_data), 32'(last_data));
    end
  endtask

  task automatic idle(input int k);
    for (int c = 0; c < k; c++) begin
      @(negedge CLK);
      i_valid = 1'b0;
      i_sof   = 1'b0;
      i_data  = 16'($urandom);
      @(posedge CLK);
      #1;
      check("gap_valid", 32'(o_valid), 32'd0);
      check("gap_err", 32'(o_err), 32'd0);
      check("gap_data", 32'(o_data), 32'(last_data));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_sof"}, 32'(o_sof), 32'd0);
    check({tag, "_half"}, 32'(o_half), 32'd0);
    check({tag, "_sat"}, 32'(o_sat), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_data"}, 32'(o_data), 32'd0);
  endtask

  task automatic set_tw(input logic [15:0] w);
    for (int k = 0; k < D; k++) tw_rom[k] = w;
  endtask

  task automatic ramp_frames(input int max_gap);
    for (int n = 0; n < 2*D; n++) begin
      send(n + 1, 0, n == 0);
      if (max_gap > 0) idle($urandom_range(1, max_gap));
    end
    for (int n = 0; n < 2*D; n++) begin
      send(0, 0, n == 0);
      if (max_gap > 0) idle($urandom_range(1, max_gap));
    end
  endtask

  initial begin
    RST     = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_data  = '0;
    set_tw(16'h4000);
    model_reset();

    // Reset held with input activity.
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      i_valid = c[0];
      i_sof   = 1'b1;
      i_data  = 16'($urandom);
      @(posedge CLK);
      #1;
      check_zero("rst");
    end
    @(negedge CLK);
    i_valid = 1'b0;
    i_sof   = 1'b0;
    RST     = 1'b1;

    set_tw(16'h4000);
    ramp_frames(0);
    set_tw(16'h00C0);
    ramp_frames(0);

    // Saturating difference.
    set_tw(16'h7F00);
    for (int n = 0; n < 2*D; n++)
      send((n == 0) ? 127 : ((n == D) ? -128 : 0), 0, n == 0);
    for (int n = 0; n < 2*D; n++) send(0, 0, n == 0);

    set_tw(16'h4000);
    ramp_frames(3);

    // Mid-frame restart at cnt=2.
    send(9, 1, 1'b1);
    send(-7, 2, 1'b0);
    send(3, 3, 1'b1);
    for (int n = 1; n < 2*D; n++) send(n * 5, -n, 1'b0);
    for (int n = 0; n < 2*D; n++) send(0, 0, n == 0);

    // Random traffic.
    for (int k = 0; k < D; k++) tw_rom[k] = 16'($urandom);
    for (int s = 0; s < 120; s++) begin
      logic [7:0] rr, ri;
      bit sof;
      rr  = 8'($urandom);
      ri  = 8'($urandom);
      sof = (pos == 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      send(int'($signed(rr)), int'($signed(ri)), sof);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Asynchronous reset in the middle of a frame.
    set_tw(16'h4000);
    for (int n = 0; n < D + 2; n++) send(n + 2, n, n == 0);
    #2;
    RST = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge CLK);
    i_valid = 1'b0;
    i_sof   = 1'b0;
    RST     = 1'b1;
    model_reset();
    ramp_frames(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
